// File: rtl/mult32x32_job_sequencer_pkg.sv
// Shared types for the 32x32 multiplier job sequencer: operand/product words,
// the buffered operand pair and the issue FSM states.
package mult_pkg;
  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned PRODUCT_W = 64;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } op_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/mult32x32_job_sequencer_fifo.sv
// Synchronous operand-pair FIFO; head is registered storage, so a pushed
// entry becomes visible at the output one cycle after the push.
module mult_op_fifo
  import mult_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  op_pair_t wdata,
  output op_pair_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  op_pair_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/mult32x32_job_sequencer.sv
// Feeds buffered operand pairs to mult32x32_fast one at a time over start/busy
// and returns each product, in issue order, on a valid/ready output.
module mult32x32_job_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product
);
  seq_state_t state_q;
  seq_state_t state_d;
  op_pair_t   head;
  op_pair_t   in_pair;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       capture;
  logic       out_free;

  // Ready is held low while reset is asserted, independent of FIFO contents.
  assign in_ready = !fifo_full & !reset;
  assign push     = in_valid & in_ready;
  assign out_free = !out_valid | out_ready;
  assign in_pair  = '{a: in_a, b: in_b};

  mult_op_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_pair),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // HOLD parks a finished product until the output register can take it.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !mult_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!mult_busy) begin
          if (out_free) begin
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands load only on the pop edge, so they stay frozen through the busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      mult_start <= pop;
      if (pop) begin
        mult_a <= head.a;
        mult_b <= head.b;
      end
      if (capture) begin
        out_valid   <= 1'b1;
        out_product <= mult_product;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult32x32_job_sequencer.sv
// Self-checking bench: sequencer in front of a behavioural start/busy multiplier,
// with results compared against a queue of a*b products from accepted inputs.
module tb_mult32x32_job_sequencer;
  import mult_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MULT_LAT   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mult_start;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_busy;
  logic [63:0] mult_product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_product;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [31:0] pa[$];
  logic [31:0] pb[$];
  int          start_cnt = 0;
  int          valid_cnt = 0;
  int          hold_err = 0;
  bit          full_seen;
  int unsigned mcnt;
  logic [31:0] ia, ib;

  always #5 clk = ~clk;

  mult32x32_job_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product)
  );

  // Multiplier stand-in: busy rises the cycle after start, product computed from
  // the operands present when busy falls; garbage while busy.
  always @(posedge clk) begin
    if (reset) begin
      mult_busy    <= 1'b0;
      mcnt         <= 0;
      mult_product <= '0;
    end else if (mult_start && !mult_busy) begin
      mult_busy    <= 1'b1;
      mcnt         <= MULT_LAT - 1;
      mult_product <= {$urandom, $urandom};
    end else if (mult_busy) begin
      if (mcnt == 0) begin
        mult_busy    <= 1'b0;
        mult_product <= 64'(mult_a) * 64'(mult_b);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Reference model and output collection at the handshakes.
  always @(posedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) exp_q.push_back(64'(in_a) * 64'(in_b));
      if (out_valid && out_ready) got_q.push_back(out_product);
      if (out_valid) valid_cnt++;
      if (mult_start) begin
        start_cnt++;
        ia = mult_a;
        ib = mult_b;
      end else if (mult_busy && (mult_a !== ia || mult_b !== ib)) begin
        hold_err++;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives the pa/pb queues with in_valid held high; returns at a negedge.
  task automatic push_burst(input int budget);
    int idx = 0;
    int cyc = 0;
    bit took;
    full_seen = 1'b0;
    @(negedge clk);
    if (pa.size() == 0) return;
    in_valid = 1'b1;
    in_a = pa[0];
    in_b = pb[0];
    while (idx < pa.size() && cyc < budget) begin
      took = in_ready;
      if (!in_ready) full_seen = 1'b1;
      @(negedge clk);
      cyc++;
      if (took) begin
        idx++;
        if (idx < pa.size()) begin
          in_a = pa[idx];
          in_b = pb[idx];
        end
      end
    end
    in_valid = 1'b0;
    pa.delete();
    pb.delete();
  endtask

  task automatic wait_got(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || mult_start !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: out_valid=%b mult_start=%b in_ready=%b, want 0/0/0",
                 i, out_valid, mult_start, in_ready);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_product !== 64'd0 ||
        mult_a !== 32'd0 || mult_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b out_product=%h mult_a=%h mult_b=%h, want 1/0/0/0/0",
               in_ready, out_valid, out_product, mult_a, mult_b);
    end
  endtask

  task automatic test_single();
    int s0, v0;
    out_ready = 1'b1;
    s0 = start_cnt;
    v0 = valid_cnt;
    pa.push_back(32'd3);
    pb.push_back(32'd5);
    push_burst(50);
    wait_got(1, 100);
    cycles(3);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 64'd15) begin
      errors++;
      $display("FAIL single_product: n=%0d first=%0d, want n=1 value=15", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 64'd0);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL single_start_pulses: got %0d, want 1", start_cnt - s0);
    end
    checks++;
    if (valid_cnt - v0 !== 1) begin
      errors++;
      $display("FAIL single_valid_cycles: got %0d, want 1", valid_cnt - v0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_pair_masked();
    logic [31:0] a, b;
    a = 32'd212533061;
    b = 32'd342824687;
    out_ready = 1'b1;
    hold_err = 0;
    pa.push_back(a);
    pb.push_back(b);
    pa.push_back(a & 32'hFFFF0000);
    pb.push_back(b & 32'hFFFF0000);
    push_burst(50);
    wait_got(2, 200);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL pair_count: got %0d results, want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 64'd72861580114476907) begin
        errors++;
        $display("FAIL pair_first: got %0d, want 72861580114476907", got_q[0]);
      end
      checks++;
      if (got_q[1] !== 64'(a & 32'hFFFF0000) * 64'(b & 32'hFFFF0000)) begin
        errors++;
        $display("FAIL pair_masked: got %h, want %h", got_q[1],
                 64'(a & 32'hFFFF0000) * 64'(b & 32'hFFFF0000));
      end
    end
    checks++;
    if (hold_err !== 0) begin
      errors++;
      $display("FAIL operand_hold: %0d busy cycles with changed mult_a/mult_b, want 0", hold_err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stall();
    int c = 0;
    int bad = 0;
    out_ready = 1'b0;
    pa.push_back(32'hFFFFFFFF);
    pb.push_back(32'hFFFFFFFF);
    pa.push_back($urandom);
    pb.push_back($urandom);
    push_burst(50);
    while (!out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_product !== 64'hFFFFFFFE00000001) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_stable: %0d cycles not valid with FFFFFFFE00000001 (last valid=%b prod=%h)",
               bad, out_valid, out_product);
    end
    checks++;
    if (dut.state_q !== HOLD) begin
      errors++;
      $display("FAIL stall_hold_state: state=%0d, want %0d", dut.state_q, HOLD);
    end
    out_ready = 1'b1;
    wait_got(2, 100);
    checks++;
    if (got_q.size() !== 2 || exp_q.size() !== 2) begin
      errors++;
      $display("FAIL stall_count: got %0d results (model %0d), want 2", got_q.size(), exp_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 64'hFFFFFFFE00000001 || got_q[1] !== exp_q[1]) begin
        errors++;
        $display("FAIL stall_values: got %h %h, want FFFFFFFE00000001 %h", got_q[0], got_q[1], exp_q[1]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      pa.push_back($urandom);
      pb.push_back($urandom);
    end
    push_burst(300);
    checks++;
    if (full_seen !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: in_ready never dropped, want a drop when full");
    end
    wait_got(FIFO_DEPTH + 2, 400);
    checks++;
    if (got_q.size() !== FIFO_DEPTH + 2 || exp_q.size() !== FIFO_DEPTH + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d model %0d, want %0d", got_q.size(), exp_q.size(), FIFO_DEPTH + 2);
    end else begin
      for (int i = 0; i < FIFO_DEPTH + 2; i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL b2b_order: %0d results out of order or wrong (first got %h want %h)",
                 bad, got_q[0], exp_q[0]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int bad = 0;
    int n = 20;
    for (int i = 0; i < n; i++) begin
      pa.push_back($urandom);
      pb.push_back($urandom);
    end
    fork
      push_burst(2000);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    wait_got(n, 1000);
    checks++;
    if (got_q.size() !== n || exp_q.size() !== n) begin
      errors++;
      $display("FAIL random_count: got %0d model %0d, want %0d", got_q.size(), exp_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL random_values: %0d of %0d results differ from model", bad, n);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    int c = 0;
    int s0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pa.push_back($urandom);
      pb.push_back($urandom);
    end
    push_burst(50);
    while (!(dut.state_q === WAIT && dut.u_fifo.count === 3'd2) && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 50) begin
      errors++;
      $display("FAIL midflight_setup: WAIT with 2 queued not reached, state=%0d", dut.state_q);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dut.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL midflight_reset: out_valid=%b fifo_empty=%b, want 0/1", out_valid, dut.fifo_empty);
    end
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    s0 = start_cnt;
    cycles(30);
    checks++;
    if (got_q.size() !== 0 || start_cnt !== s0) begin
      errors++;
      $display("FAIL midflight_stale: %0d results and %0d starts after reset, want 0/0",
               got_q.size(), start_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair_masked();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
